hex_counter_display: RTL and testbench

Parametrised multi-digit hexadecimal up/down counter driving a time-multiplexed common-anode 7-segment display. Two push-buttons are synchronised and debounced, each debounced press steps the counter by one, and the value is scanned across NUM_DIGITS digits with optional leading-zero blanking. Sits between the board push-buttons and the 7-segment connector in the FPGA top level.

---
 rtl/hex_counter_display_if.sv | 22 ++
 rtl/hex_counter_display.sv | 123 ++++++++++++
 tb/tb_hex_counter_display.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_counter_display_if.sv
// Push-button / 7-segment connector bundle for hex_counter_display.
// The master drives the buttons and clear; the slave (the counter) drives the display.
interface hex_counter_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      btn_inc;
    logic                      btn_dec;
    logic                      clear;
    logic [4*NUM_DIGITS-1:0]   count;
    logic [7:0]                to_7_seg_n;
    logic [NUM_DIGITS-1:0]     to_7_seg_sel_n;

    modport master (
        output btn_inc, btn_dec, clear,
        input  count, to_7_seg_n, to_7_seg_sel_n
    );

    modport slave (
        input  btn_inc, btn_dec, clear,
        output count, to_7_seg_n, to_7_seg_sel_n
    );
endinterface

// File: rtl/hex_counter_display.sv
// Debounced up/down hex counter with a time-multiplexed common-anode 7-segment scan.
// Button path: 2-flop synchroniser -> stability-window debouncer -> one-cycle press pulse.
module hex_counter_display #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 100000,
    parameter bit BLANK_LEADING   = 1'b1
) (
    input logic clk,
    input logic reset,
    hex_counter_display_if.slave bus
);
    localparam int CW    = 4 * NUM_DIGITS;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SC_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Bit 0 is the increment button, bit 1 the decrement button.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            level_q, level_d;
    logic [1:0]            pulse_q, pulse_d;
    logic [DB_W-1:0]       db_cnt_q [2];
    logic [DB_W-1:0]       db_cnt_d [2];
    logic [CW-1:0]         count_q, count_d;
    logic [SC_W-1:0]       scan_q, scan_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [CW-1:0]         shifted;
    logic                  blank;

    function automatic logic [7:0] encode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign btn_raw = {bus.btn_dec, bus.btn_inc};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        level_d  = level_q;
        pulse_d  = '0;
        db_cnt_d = db_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == level_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (db_cnt_q[b] == DB_LAST) begin
                level_d[b]  = sync2_q[b];
                db_cnt_d[b] = '0;
                pulse_d[b]  = sync2_q[b];   // only a rising acceptance is a press
            end else begin
                db_cnt_d[b] = db_cnt_q[b] + 1'b1;
            end
        end

        count_d = count_q;
        if (bus.clear) begin
            count_d = '0;
        end else begin
            case (pulse_q)
                2'b01:   count_d = count_q + 1'b1;
                2'b10:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SC_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Digit i is blank when it and every more-significant nibble are zero.
        shifted = count_q >> (4 * idx_q);
        blank   = BLANK_LEADING && (idx_q != '0) && (shifted == '0);
        seg_d   = blank ? 8'hFF : encode(shifted[3:0]);
        sel_d   = ~(NUM_DIGITS'(1) << idx_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            // NOTE: the two-entry debounce counter array is ordinary state and is reset like any flop.
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
            count_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            sel_q   <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int b = 0; b < 2; b++) db_cnt_q[b] <= db_cnt_d[b];
            count_q <= count_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.count          = count_q;
    assign bus.to_7_seg_n     = seg_q;
    assign bus.to_7_seg_sel_n = sel_q;
endmodule

// File: tb/tb_hex_counter_display.sv
// Directed + randomised bench for hex_counter_display, checked against a behavioural model
// built from button delay history, stable-run debouncing and modulo arithmetic.
module tb_hex_counter_display;
    localparam int ND = 4;
    localparam int DB = 4;
    localparam int SC = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hex_counter_display_if #(.NUM_DIGITS(ND)) bus();

    hex_counter_display #(
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .SCAN_CYCLES(SC), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] sel_seq [8] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};

    // Behavioural model state.
    int          cyc;
    logic [15:0] m_count;
    logic [15:0] shown;
    logic [7:0]  m_seg;
    logic [3:0]  m_sel;
    bit          raw_now [2];
    bit          hist1 [2];
    bit          hist2 [2];
    bit          acc_lvl [2];
    int          run_len [2];
    bit          press [2];
    bit          new_press [2];
    int          dig;
    bit          samp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; m_count = '0; m_seg = 8'hFF; m_sel = 4'hF;
            for (int b = 0; b < 2; b++) begin
                hist1[b] = 0; hist2[b] = 0; acc_lvl[b] = 0; run_len[b] = 0; press[b] = 0;
            end
        end else begin
            // Display: digit chosen purely by elapsed cycles since reset.
            shown = m_count;
            dig   = (cyc / SC) % ND;
            m_sel = ~(4'b0001 << dig);
            m_seg = (dig > 0 && (shown >> (4 * dig)) == 16'h0) ? 8'hFF : seg_tab[(shown >> (4 * dig)) & 16'hF];
            cyc++;
            if (bus.clear)              m_count = 16'h0;
            else if (press[0] && !press[1]) m_count = m_count + 16'h1;
            else if (press[1] && !press[0]) m_count = m_count - 16'h1;
            raw_now[0] = bus.btn_inc;
            raw_now[1] = bus.btn_dec;
            for (int b = 0; b < 2; b++) begin
                samp = hist2[b];
                new_press[b] = 0;
                if (samp != acc_lvl[b]) begin
                    run_len[b]++;
                    if (run_len[b] == DB) begin
                        acc_lvl[b]   = samp;
                        run_len[b]   = 0;
                        new_press[b] = samp;
                    end
                end else begin
                    run_len[b] = 0;
                end
                press[b] = new_press[b];
                hist2[b] = hist1[b];
                hist1[b] = raw_now[b];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("model_count", bus.count, m_count);
        check("model_seg", bus.to_7_seg_n, m_seg);
        check("model_sel", bus.to_7_seg_sel_n, m_sel);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_btn(input bit dec);
        if (dec) bus.btn_dec = 1'b1; else bus.btn_inc = 1'b1;
        ticks(6);
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        ticks(6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, bus.count, 16'h0);
        check({tag, "_seg"}, bus.to_7_seg_n, 8'hFF);
        check({tag, "_sel"}, bus.to_7_seg_sel_n, 4'hF);
    endtask

    task automatic show_digit(input logic [3:0] sel, input logic [7:0] seg, input string tag);
        for (int k = 0; k < 16 && bus.to_7_seg_sel_n !== sel; k++) tick();
        check({tag, "_sel"}, bus.to_7_seg_sel_n, sel);
        check({tag, "_seg"}, bus.to_7_seg_n, seg);
    endtask

    initial begin
        int n;
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        bus.clear   = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Idle scan after reset.
        for (int k = 0; k < 16; k++) begin
            tick();
            check("idle_sel", bus.to_7_seg_sel_n, sel_seq[k % 8]);
            check("idle_seg", bus.to_7_seg_n, (sel_seq[k % 8] == 4'hE) ? 8'hC0 : 8'hFF);
        end
        check("idle_count", bus.count, 16'h0);

        // Press latency: change lands on the seventh edge after the button rises.
        bus.btn_inc = 1'b1;
        repeat (6) tick();
        check("inc_before", bus.count, 16'h0);
        tick();
        check("inc_first", bus.count, 16'h1);
        ticks(3);
        check("inc_held_once", bus.count, 16'h1);
        bus.btn_inc = 1'b0;
        ticks(8);
        repeat (20) press_btn(1'b0);
        check("inc_x21", bus.count, 16'h0015);
        show_digit(4'hD, 8'hF9, "dig1");
        show_digit(4'hE, 8'h92, "dig0");
        show_digit(4'hB, 8'hFF, "dig2_blank");

        // Bouncing button: no acceptance until it stays put.
        for (int i = 0; i < 20; i++) begin
            bus.btn_inc = (i % 2 == 0);
            ticks(2);
        end
        check("bounce_none", bus.count, 16'h0015);
        bus.btn_inc = 1'b1;
        repeat (6) tick();
        check("bounce_wait", bus.count, 16'h0015);
        tick();
        check("bounce_one", bus.count, 16'h0016);
        bus.btn_inc = 1'b0;
        ticks(8);

        // Clear, then wrap below zero and back.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear", bus.count, 16'h0);
        press_btn(1'b1);
        check("dec_wrap", bus.count, 16'hFFFF);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("all_8e", bus.to_7_seg_n, 8'h8E);
        end
        press_btn(1'b0);
        check("inc_wrap", bus.count, 16'h0);

        // Build 0x0123, then simultaneous presses and clear-over-press.
        repeat (291) press_btn(1'b0);
        check("count_123", bus.count, 16'h0123);
        bus.btn_inc = 1'b1;
        bus.btn_dec = 1'b1;
        ticks(6);
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        ticks(6);
        check("both_pulses", bus.count, 16'h0123);
        bus.btn_inc = 1'b1;
        repeat (6) tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_wins", bus.count, 16'h0);
        tick();
        check("clear_wins_after", bus.count, 16'h0);
        bus.btn_inc = 1'b0;
        ticks(6);

        // Reset partway through a decrement debounce, button held throughout.
        bus.btn_dec = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        reset = 1'b0;
        repeat (6) tick();
        check("rel_wait", bus.count, 16'h0);
        tick();
        check("rel_dec", bus.count, 16'hFFFF);
        bus.btn_dec = 1'b0;
        ticks(6);

        // Random button activity with occasional clears.
        for (int it = 0; it < 250; it++) begin
            bus.btn_inc = 1'($urandom_range(0, 1));
            bus.btn_dec = ($urandom_range(0, 3) == 0);
            bus.clear   = ($urandom_range(0, 19) == 0);
            n = $urandom_range(1, 8);
            tick();
            bus.clear = 1'b0;
            ticks(n - 1);
        end
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        ticks(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
